pipe_stall_ctrl: RTL and testbench
==================================

// Module: pipe_stall_ctrl
// PURPOSE
//   Central pipeline stall controller for the 5-stage CPU. Collects stall requests (ID load-use
//   interlock, EX multi-cycle unit, MEM data-SRAM wait), resolves priority, drives the shared
//   stall bus to IF/ID/EX/MEM/WB, and owns the ID instruction hold buffer so an instruction
//   returned by the synchronous inst SRAM is not lost while ID is frozen.
// PARAMETERS
//   BUSY_MAX  64  max consecutive EX-busy cycles before busy_timeout is flagged
//   CNT_W     32  width of the saturating stall-cycle performance counter
// PORTS
//   clk              in   1   core clock, single domain
//   rst              in   1   asynchronous, active-high reset
//   id_ld_use_req    in   1   ID: rs/rt matches EX-stage lw destination (non-zero)
//   ex_busy_req      in   1   EX: multi-cycle unit (mul/div) not done
//   mem_wait_req     in   1   MEM: data SRAM access not complete
//   inst_sram_rdata  in   32  raw instruction from inst SRAM
//   stall            out  `StallBus (6)  bit0 PC,1 IF,2 ID,3 EX,4 MEM,5 WB; `Stop=1
//   id_inst          out  32  instruction presented to ID decode
//   busy_timeout     out  1   sticky: EX busy exceeded BUSY_MAX
//   stall_cycles     out  CNT_W  count of cycles with stall!=0, saturates at all-ones
// BEHAVIOUR
//   Reset (async, any time): state=RUN, hold_valid=0, hold_inst=0, busy_cnt=0,
//     busy_timeout=0, stall_cycles=0; stall forced 6'b0 while rst=1; id_inst=inst_sram_rdata.
//   stall is combinational from requests + state (0-cycle latency); all else registered.
//   Priority (highest first) and encoding:
//     mem_wait_req  -> 6'b011111 (PC..MEM held, bubble into WB)
//     ex_busy_req   -> 6'b001111 (PC..EX held, bubble into MEM)
//     id_ld_use_req -> 6'b000111 (PC..ID held, bubble into EX)
//     none          -> 6'b000000
//   FSM states: RUN, LDUSE, EXWAIT, MEMWAIT; next state = state of the winning request, RUN if none.
//     LDUSE lasts exactly 1 cycle: in LDUSE, id_ld_use_req is ignored (lw has advanced to MEM,
//     forwarding covers it) -> returns to RUN unless a higher-priority request is active.
//     EXWAIT: busy_cnt increments each cycle; when busy_cnt==BUSY_MAX-1 and ex_busy_req still 1,
//     busy_timeout sets (sticky until reset); stall keeps following ex_busy_req. busy_cnt clears
//     on any cycle ex_busy_req=0 or mem_wait_req=1.
//     MEMWAIT: held while mem_wait_req=1; a coincident ex_busy_req resumes as EXWAIT afterwards.
//   Instruction hold buffer:
//     edge with stall[2]=1 and hold_valid=0 -> hold_inst<=inst_sram_rdata, hold_valid<=1.
//     edge with stall[2]=0 -> hold_valid<=0. While hold_valid=1, hold_inst unchanged.
//     id_inst = hold_valid ? hold_inst : inst_sram_rdata.
//   Simultaneous requests: only highest priority is encoded; lower ones are re-evaluated each cycle.
//   Request dropped mid-stall: stall returns to 0 same cycle; hold buffer releases next edge.
//   stall_cycles: +1 on each edge with stall!=0, saturates, never wraps.
// STRUCTURE
//   Shared defines.vh: `StallBus, `Stop/`NoStop, stall encodings STALL_MEM/STALL_EX/STALL_ID,
//     FSM state codes (2-bit).
//   One sub-module: inst_hold_buf (32-bit capture reg + valid, mux to id_inst). FSM, priority
//     encoder and counters stay in the top.
// TESTING
//   Reset: assert rst mid-EXWAIT -> stall=0 immediately, busy_timeout=0, stall_cycles=0, id_inst=rdata.
//   Load-use: id_ld_use_req=1 held 2 cycles, rdata=0x8C220004 -> stall=000111 for 1 cycle only,
//     id_inst=0x8C220004 in the cycle after, stall_cycles=1.
//   EX busy 5 cycles with id_ld_use_req=1 -> stall=001111 x5 then 000000; no LDUSE cycle after.
//   mem_wait + ex_busy together 3 cycles, then ex_busy alone 2 -> 011111 x3, 001111 x2, 000000.
//   Hold buffer: stall[2]=1 at edge with rdata=0x24010001, rdata then changes to 0xFFFFFFFF ->
//     id_inst stays 0x24010001 until the edge after stall clears.
//   Timeout: BUSY_MAX=4, ex_busy_req=1 for 6 cycles -> busy_timeout=1 at 4th edge, stays 1 after.
//   Counter saturation: CNT_W=3, 10 stall cycles -> stall_cycles=3'b111.

Source files
------------

// File: rtl/pipe_stall_ctrl_pkg.sv
// rtl/pipe_stall_ctrl_pkg.sv - shared stall-bus encodings and FSM state codes
// Purpose: common definitions for the pipeline stall controller.
//   STALL_W            width of the stall bus (bit0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB)
//   STOP               value of a stall bit that freezes its stage
//   STALL_ID/EX/MEM    bus encodings for each request source
//   state_t            controller FSM states
//   stall_of_state()   maps a (winning-request) state to its stall encoding
package pipe_stall_ctrl_pkg;

  localparam int STALL_W      = 6;
  localparam int STALL_ID_BIT = 2;

  localparam logic STOP = 1'b1;

  localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
  localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
  localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
  localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_LDUSE   = 2'd1,
    ST_EXWAIT  = 2'd2,
    ST_MEMWAIT = 2'd3
  } state_t;

  // The next state always names the winning request, so the stall bus
  // is simply the encoding of that state.
  function automatic logic [STALL_W-1:0] stall_of_state(input state_t s);
    logic [STALL_W-1:0] enc;
    enc = STALL_NONE;
    case (s)
      ST_LDUSE:   enc = STALL_ID;
      ST_EXWAIT:  enc = STALL_EX;
      ST_MEMWAIT: enc = STALL_MEM;
      default:    enc = STALL_NONE;
    endcase
    return enc;
  endfunction

endpackage

// File: rtl/pipe_stall_ctrl_inst_hold_buf.sv
// rtl/pipe_stall_ctrl_inst_hold_buf.sv - ID instruction hold buffer
// Purpose: captures the instruction returned by the synchronous inst SRAM
//   on the first frozen edge of ID and presents it to decode until ID moves.
// Ports:
//   clk, rst          core clock, async active-high reset
//   stall_id          stall bus bit for the ID stage
//   inst_sram_rdata   raw instruction from inst SRAM
//   id_inst           instruction presented to ID decode
module pipe_stall_ctrl_inst_hold_buf
  import pipe_stall_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_id,
  input  logic [31:0] inst_sram_rdata,
  output logic [31:0] id_inst
);

  logic        hold_valid;
  logic [31:0] hold_inst;

  // Only the first frozen edge captures: later SRAM data belongs to a
  // younger fetch and must not overwrite the instruction ID is holding.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_valid <= 1'b0;
      hold_inst  <= 32'h0;
    end else if (stall_id == STOP) begin
      if (!hold_valid) begin
        hold_inst  <= inst_sram_rdata;
        hold_valid <= 1'b1;
      end
    end else begin
      hold_valid <= 1'b0;
    end
  end

  assign id_inst = hold_valid ? hold_inst : inst_sram_rdata;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// rtl/pipe_stall_ctrl.sv - central pipeline stall controller
// Purpose: prioritises stall requests, drives the shared stall bus, tracks
//   EX-busy timeout and counts stalled cycles.
// Ports:
//   clk, rst          core clock, async active-high reset
//   id_ld_use_req     ID load-use interlock request
//   ex_busy_req       EX multi-cycle unit busy
//   mem_wait_req      MEM data SRAM wait
//   inst_sram_rdata   raw instruction from inst SRAM
//   stall             stall bus (bit0 PC .. bit5 WB), combinational
//   id_inst           instruction to ID decode
//   busy_timeout      sticky flag: EX busy exceeded BUSY_MAX cycles
//   stall_cycles      saturating count of cycles with a non-zero stall bus
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int BUSY_MAX = 64,
  parameter int CNT_W    = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_ld_use_req,
  input  logic               ex_busy_req,
  input  logic               mem_wait_req,
  input  logic [31:0]        inst_sram_rdata,
  output logic [STALL_W-1:0] stall,
  output logic [31:0]        id_inst,
  output logic               busy_timeout,
  output logic [CNT_W-1:0]   stall_cycles
);

  localparam int             BCW       = (BUSY_MAX > 1) ? $clog2(BUSY_MAX) : 1;
  localparam logic [BCW-1:0] BUSY_LAST = BCW'(BUSY_MAX - 1);

  state_t         state;
  state_t         next_state;
  logic [BCW-1:0] busy_cnt;
  logic           ex_wins;

  // Priority: MEM > EX > ID. A load-use request seen while already in
  // LDUSE is the same hazard; the lw has moved to MEM and forwarding
  // resolves it, so it must not stall a second cycle.
  always_comb begin
    next_state = ST_RUN;
    if (mem_wait_req)
      next_state = ST_MEMWAIT;
    else if (ex_busy_req)
      next_state = ST_EXWAIT;
    else if (id_ld_use_req && state != ST_LDUSE)
      next_state = ST_LDUSE;
  end

  assign stall   = rst ? STALL_NONE : stall_of_state(next_state);
  assign ex_wins = (next_state == ST_EXWAIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_RUN;
      busy_cnt     <= '0;
      busy_timeout <= 1'b0;
      stall_cycles <= '0;
    end else begin
      state <= next_state;

      // Counter parks at BUSY_LAST so a very long busy run cannot wrap.
      if (!ex_wins)
        busy_cnt <= '0;
      else if (busy_cnt != BUSY_LAST)
        busy_cnt <= busy_cnt + 1'b1;

      if (ex_wins && busy_cnt == BUSY_LAST)
        busy_timeout <= 1'b1;

      if (stall != STALL_NONE && stall_cycles != {CNT_W{1'b1}})
        stall_cycles <= stall_cycles + 1'b1;
    end
  end

  pipe_stall_ctrl_inst_hold_buf u_hold_buf (
    .clk             (clk),
    .rst             (rst),
    .stall_id        (stall[STALL_ID_BIT]),
    .inst_sram_rdata (inst_sram_rdata),
    .id_inst         (id_inst)
  );

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb/tb_pipe_stall_ctrl.sv - directed self-checking bench for pipe_stall_ctrl
module tb_pipe_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        id_ld_use_req = 1'b0;
  logic        ex_busy_req = 1'b0;
  logic        mem_wait_req = 1'b0;
  logic [31:0] inst_sram_rdata = 32'h0;
  logic [5:0]  stall;
  logic [31:0] id_inst;
  logic        busy_timeout;
  logic [2:0]  stall_cycles;

  int n_vec = 0;
  int n_err = 0;

  pipe_stall_ctrl #(.BUSY_MAX(4), .CNT_W(3)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_ld_use_req   (id_ld_use_req),
    .ex_busy_req     (ex_busy_req),
    .mem_wait_req    (mem_wait_req),
    .inst_sram_rdata (inst_sram_rdata),
    .stall           (stall),
    .id_inst         (id_inst),
    .busy_timeout    (busy_timeout),
    .stall_cycles    (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    id_ld_use_req = 1'b0;
    ex_busy_req = 1'b0;
    mem_wait_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    ex_busy_req = 1'b1;
    inst_sram_rdata = 32'h11111111;
    for (int i = 0; i < 5; i++) tick();
    n_vec++;
    if (busy_timeout !== 1'b1) begin
      n_err++; $display("FAIL reset_pre_timeout: got %b want 1", busy_timeout);
    end
    @(negedge clk);
    inst_sram_rdata = 32'h22222222;
    rst = 1'b1;
    #1;
    n_vec++;
    if (stall !== 6'b000000) begin
      n_err++; $display("FAIL reset_stall: got %b want 000000", stall);
    end
    n_vec++;
    if (busy_timeout !== 1'b0) begin
      n_err++; $display("FAIL reset_timeout: got %b want 0", busy_timeout);
    end
    n_vec++;
    if (stall_cycles !== 3'd0) begin
      n_err++; $display("FAIL reset_stall_cycles: got %0d want 0", stall_cycles);
    end
    n_vec++;
    if (id_inst !== 32'h22222222) begin
      n_err++; $display("FAIL reset_id_inst: got %h want 22222222", id_inst);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_vec++;
    if (stall !== 6'b001111) begin
      n_err++; $display("FAIL reset_release_stall: got %b want 001111", stall);
    end
    ex_busy_req = 1'b0;
  endtask

  task automatic test_load_use();
    do_reset();
    inst_sram_rdata = 32'h8C220004;
    id_ld_use_req = 1'b1;
    #1;
    n_vec++;
    if (stall !== 6'b000111) begin
      n_err++; $display("FAIL lduse_stall_c0: got %b want 000111", stall);
    end
    tick();
    n_vec++;
    if (stall !== 6'b000000) begin
      n_err++; $display("FAIL lduse_stall_c1: got %b want 000000", stall);
    end
    n_vec++;
    if (id_inst !== 32'h8C220004) begin
      n_err++; $display("FAIL lduse_id_inst: got %h want 8c220004", id_inst);
    end
    n_vec++;
    if (stall_cycles !== 3'd1) begin
      n_err++; $display("FAIL lduse_stall_cycles: got %0d want 1", stall_cycles);
    end
    tick();
    id_ld_use_req = 1'b0;
    #1;
    n_vec++;
    if (stall_cycles !== 3'd1 || stall !== 6'b000000) begin
      n_err++; $display("FAIL lduse_after: got cnt=%0d stall=%b want cnt=1 stall=000000", stall_cycles, stall);
    end
  endtask

  task automatic test_ex_busy();
    do_reset();
    ex_busy_req = 1'b1;
    id_ld_use_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_vec++;
      if (stall !== 6'b001111) begin
        n_err++; $display("FAIL exbusy_stall[%0d]: got %b want 001111", i, stall);
      end
      tick();
    end
    ex_busy_req = 1'b0;
    id_ld_use_req = 1'b0;
    #1;
    n_vec++;
    if (stall !== 6'b000000) begin
      n_err++; $display("FAIL exbusy_release: got %b want 000000", stall);
    end
    tick();
    n_vec++;
    if (stall !== 6'b000000 || stall_cycles !== 3'd5) begin
      n_err++; $display("FAIL exbusy_after: got stall=%b cnt=%0d want 000000 cnt=5", stall, stall_cycles);
    end
  endtask

  task automatic test_mem_ex();
    do_reset();
    mem_wait_req = 1'b1;
    ex_busy_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_vec++;
      if (stall !== 6'b011111) begin
        n_err++; $display("FAIL memex_stall[%0d]: got %b want 011111", i, stall);
      end
      tick();
    end
    mem_wait_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_vec++;
      if (stall !== 6'b001111) begin
        n_err++; $display("FAIL memex_ex_stall[%0d]: got %b want 001111", i, stall);
      end
      tick();
    end
    ex_busy_req = 1'b0;
    #1;
    n_vec++;
    if (stall !== 6'b000000) begin
      n_err++; $display("FAIL memex_release: got %b want 000000", stall);
    end
    n_vec++;
    if (stall_cycles !== 3'd5 || busy_timeout !== 1'b0) begin
      n_err++; $display("FAIL memex_counters: got cnt=%0d to=%b want cnt=5 to=0", stall_cycles, busy_timeout);
    end
  endtask

  task automatic test_hold_buf();
    do_reset();
    inst_sram_rdata = 32'h24010001;
    ex_busy_req = 1'b1;
    tick();
    inst_sram_rdata = 32'hFFFFFFFF;
    #1;
    n_vec++;
    if (id_inst !== 32'h24010001) begin
      n_err++; $display("FAIL hold_c1: got %h want 24010001", id_inst);
    end
    tick();
    n_vec++;
    if (id_inst !== 32'h24010001) begin
      n_err++; $display("FAIL hold_c2: got %h want 24010001", id_inst);
    end
    ex_busy_req = 1'b0;
    #1;
    n_vec++;
    if (id_inst !== 32'h24010001) begin
      n_err++; $display("FAIL hold_release_same: got %h want 24010001", id_inst);
    end
    tick();
    n_vec++;
    if (id_inst !== 32'hFFFFFFFF) begin
      n_err++; $display("FAIL hold_released: got %h want ffffffff", id_inst);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    ex_busy_req = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      n_vec++;
      if (busy_timeout !== (i >= 4)) begin
        n_err++; $display("FAIL timeout_edge%0d: got %b want %b", i, busy_timeout, (i >= 4));
      end
    end
    ex_busy_req = 1'b0;
    tick();
    tick();
    n_vec++;
    if (busy_timeout !== 1'b1) begin
      n_err++; $display("FAIL timeout_sticky: got %b want 1", busy_timeout);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    mem_wait_req = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 3 || i == 7 || i == 10) begin
        n_vec++;
        if (stall_cycles !== ((i > 7) ? 3'd7 : 3'(i))) begin
          n_err++; $display("FAIL sat_edge%0d: got %0d want %0d", i, stall_cycles, (i > 7) ? 7 : i);
        end
      end
    end
    mem_wait_req = 1'b0;
    tick();
    n_vec++;
    if (stall_cycles !== 3'b111) begin
      n_err++; $display("FAIL sat_final: got %b want 111", stall_cycles);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_ex_busy();
    test_mem_ex();
    test_hold_buf();
    test_timeout();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
